fpga2hps_rd_arb: RTL and testbench
==================================

FPGA2HPS_RD_ARB -- requirements
Module: fpga2hps_rd_arb

Interface
REQ-001 Parameter: MAX_OUTST, default 4, SHALL set the maximum number of outstanding read bursts per requester, legal range 1..15.
REQ-002 clk  in  1  SHALL be the single clock; every register updates on its rising edge.
REQ-003 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-004 req0_/req1_ arvalid in 1, arready out 1, araddr in 32, arlen in 4, arsize in 3: per-requester read-address channel; requester 0 is video scanout, requester 1 is the general master.
REQ-005 req0_/req1_ rvalid out 1, rready in 1, rdata out 32, rresp out 2, rlast out 1: per-requester read-data channel.
REQ-006 hps_ arvalid out 1, arready in 1, arid out 8, araddr out 32, arlen out 4, arsize out 3, arburst out 2, arcache out 4, arprot out 3, arlock out 2: shared AXI3 AR channel to the FPGA-to-HPS bridge.
REQ-007 hps_ rvalid in 1, rready out 1, rid in 8, rdata in 32, rresp in 2, rlast in 1: shared AXI3 R channel from the bridge.

Function
REQ-008 The AR-side FSM SHALL have two states: IDLE, in which it accepts one request, and ISSUE, in which it holds hps_arvalid high.
REQ-009 In IDLE, a requester SHALL be eligible only when its arvalid=1 and its outstanding count < MAX_OUTST.
REQ-010 The winner's arready SHALL be asserted combinationally in IDLE; the loser's arready SHALL be 0; in ISSUE both arready SHALL be 0.
REQ-011 When a requester handshakes, its araddr, arlen and arsize and the index of the winner SHALL be registered, and the FSM SHALL move to ISSUE, so hps_arvalid rises exactly 1 cycle after the requester handshake.
REQ-012 In ISSUE, all hps_ar* outputs SHALL stay stable until hps_arvalid and hps_arready are both high; on that handshake the FSM SHALL return to IDLE, giving at most one request per 2 cycles.
REQ-013 The downstream AR signals SHALL be driven as follows: hps_arid = {7'b0, winner index}; hps_arburst = 2'b01 (INCR); hps_arcache = 4'b0011; hps_arprot = 3'b000; hps_arlock = 2'b00.
REQ-014 Default arbitration SHALL be round-robin: when both requesters are eligible, the one not granted last wins; the pointer SHALL update only on a requester handshake.
REQ-015 Each requester SHALL have an outstanding counter of width clog2(MAX_OUTST+1): it increments on the hps AR handshake for that index and decrements on an hps R handshake with rlast=1 and rid[0] equal to that index.
REQ-016 If the counter's increment and decrement events occur in the same cycle, the counter SHALL be unchanged.
REQ-017 Decrement at 0 SHALL saturate at 0, and increment at MAX_OUTST SHALL be impossible because of REQ-009.
REQ-018 R routing SHALL be combinational with zero latency and keyed on hps_rid[0] only; rid[7:1] SHALL be ignored.
REQ-019 reqN_rvalid SHALL equal hps_rvalid && rid[0]==N, and hps_rready SHALL equal the rready of the addressed requester.
REQ-020 rdata, rresp and rlast SHALL be forwarded to both requesters unmodified; they are qualified only by each requester's rvalid.
REQ-021 Interleaved R beats from the two IDs SHALL be routed beat-by-beat; no burst locking is applied on the R channel.

Reset
REQ-022 While rst=1: FSM in IDLE; hps_arvalid=0; both req arready=0; all hps_ar* payload registers=0; both counters=0; round-robin pointer = last-granted requester 1, so requester 0 wins the first tie.
REQ-023 A reset asserted in ISSUE SHALL drop hps_arvalid in the next cycle; the pending request is discarded and not replayed.
REQ-024 R beats arriving after reset SHALL still be routed by rid[0], with the counters saturating at 0.

Configuration
REQ-025 The macro FPGA2HPS_ARB_VIDEO_PRIO_EN SHALL select the arbitration policy.
REQ-026 With FPGA2HPS_ARB_VIDEO_PRIO_EN defined: requester 0 SHALL win every tie (fixed priority), and the round-robin pointer SHALL not be built.
REQ-027 Without FPGA2HPS_ARB_VIDEO_PRIO_EN: round-robin arbitration SHALL apply as in REQ-014.

Structure
REQ-028 Package fpga2hps_pkg SHALL hold the shared constants AXI_ID_W=8, AXI_BURST_INCR=2'b01, AXI_CACHE_DEF=4'b0011, AXI_PROT_DEF=3'b000 and AXI_LOCK_NORMAL=2'b00, plus the req_idx_t typedef (1 bit).
REQ-029 A sub-module arb2_rr SHALL hold the two-input grant logic and pointer, including the FPGA2HPS_ARB_VIDEO_PRIO_EN variant; the counters, FSM and R routing SHALL stay in fpga2hps_rd_arb.

Verification
REQ-030 Single read: req1 araddr=0x2000_0040, arlen=3 -> hps_arvalid rises the next cycle with arid=0x01 and arlen=3; 4 R beats with rid=0x01 go to req1 only; req1 counter goes 0->1->0.
REQ-031 Tie: both requesters valid continuously and hps_arready=1 -> grants alternate 0,1,0,1 (round-robin) or 0,0,0,0 (with FPGA2HPS_ARB_VIDEO_PRIO_EN).
REQ-032 Backpressure: hps_arready held 0 for 5 cycles during ISSUE -> araddr, arlen and arid stay stable, and neither req arready is asserted.
REQ-033 Limit: MAX_OUTST=2 and req0 issues 2 bursts with no R -> req0 arready stays 0 while req1 is still granted; an rlast beat with rid=0x00 re-enables req0 the next cycle.
REQ-034 Simultaneous: an hps AR handshake for req0 in the same cycle as an rlast beat for req0 -> req0 counter unchanged.
REQ-035 Reset during ISSUE: hps_arvalid=0 the next cycle; counters=0; the first post-reset tie is won by req0.

Source files
------------

// File: rtl/fpga2hps_pkg.sv
// rtl/fpga2hps_pkg.sv - shared AXI3 constants and types for the FPGA-to-HPS read arbiter
package fpga2hps_pkg;

  localparam int         AXI_ID_W        = 8;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEF   = 4'b0011;
  localparam logic [2:0] AXI_PROT_DEF    = 3'b000;
  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;

  // Requester index: 0 = video scanout, 1 = general master
  typedef logic req_idx_t;

  // Downstream ID carries the requester index in bit 0 only
  function automatic logic [AXI_ID_W-1:0] idx_to_id(input req_idx_t idx);
    return {{(AXI_ID_W-1){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/arb2_rr.sv
// rtl/arb2_rr.sv - two-input grant logic; FPGA2HPS_ARB_VIDEO_PRIO_EN selects fixed priority
module arb2_rr
  import fpga2hps_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt,
  output req_idx_t   win
);

`ifdef FPGA2HPS_ARB_VIDEO_PRIO_EN

  // Video scanout wins every tie; no pointer state exists in this build
  always_comb begin
    win = req[0] ? 1'b0 : 1'b1;
  end

  logic unused_prio;
  assign unused_prio = ^{clk, rst, take};

`else

  req_idx_t last_q;

  // On a tie the requester not granted last wins; otherwise the lone requester
  always_comb begin
    if (req == 2'b11) begin
      win = ~last_q;
    end else begin
      win = req[0] ? 1'b0 : 1'b1;
    end
  end

  // Pointer tracks the last requester that actually completed a handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (take) begin
      last_q <= win;
    end
  end

`endif

  assign gnt = {req[1] && win, req[0] && !win};

endmodule

// File: rtl/fpga2hps_rd_arb.sv
// rtl/fpga2hps_rd_arb.sv - two-requester AXI3 read arbiter onto the FPGA-to-HPS bridge (policy macro FPGA2HPS_ARB_VIDEO_PRIO_EN)
module fpga2hps_rd_arb
  import fpga2hps_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                rst,
  // requester 0 (video scanout)
  input  logic                req0_arvalid,
  output logic                req0_arready,
  input  logic [31:0]         req0_araddr,
  input  logic [3:0]          req0_arlen,
  input  logic [2:0]          req0_arsize,
  output logic                req0_rvalid,
  input  logic                req0_rready,
  output logic [31:0]         req0_rdata,
  output logic [1:0]          req0_rresp,
  output logic                req0_rlast,
  // requester 1 (general master)
  input  logic                req1_arvalid,
  output logic                req1_arready,
  input  logic [31:0]         req1_araddr,
  input  logic [3:0]          req1_arlen,
  input  logic [2:0]          req1_arsize,
  output logic                req1_rvalid,
  input  logic                req1_rready,
  output logic [31:0]         req1_rdata,
  output logic [1:0]          req1_rresp,
  output logic                req1_rlast,
  // bridge AR channel
  output logic                hps_arvalid,
  input  logic                hps_arready,
  output logic [AXI_ID_W-1:0] hps_arid,
  output logic [31:0]         hps_araddr,
  output logic [3:0]          hps_arlen,
  output logic [2:0]          hps_arsize,
  output logic [1:0]          hps_arburst,
  output logic [3:0]          hps_arcache,
  output logic [2:0]          hps_arprot,
  output logic [1:0]          hps_arlock,
  // bridge R channel
  input  logic                hps_rvalid,
  output logic                hps_rready,
  input  logic [AXI_ID_W-1:0] hps_rid,
  input  logic [31:0]         hps_rdata,
  input  logic [1:0]          hps_rresp,
  input  logic                hps_rlast
);

  localparam int               CNT_W   = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]       state_q;
  req_idx_t         idx_q;
  logic [31:0]      addr_q;
  logic [3:0]       len_q;
  logic [2:0]       size_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  logic [1:0] elig;
  logic [1:0] gnt;
  req_idx_t   win;
  logic       idle;
  logic       req_hs;
  logic       hps_ar_hs;
  logic       r_done;
  logic       inc0, inc1, dec0, dec1;

  // Saturating up/down step; simultaneous inc and dec cancel out
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    if (inc && !dec) begin
      return cnt + CNT_ONE;
    end else if (dec && !inc && (cnt != '0)) begin
      return cnt - CNT_ONE;
    end
    return cnt;
  endfunction

  assign idle    = (state_q == ST_IDLE) && !rst;
  assign elig[0] = req0_arvalid && (cnt0_q < CNT_MAX);
  assign elig[1] = req1_arvalid && (cnt1_q < CNT_MAX);

  arb2_rr u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (elig),
    .take (req_hs),
    .gnt  (gnt),
    .win  (win)
  );

  assign req0_arready = idle && gnt[0];
  assign req1_arready = idle && gnt[1];
  assign req_hs       = req0_arready || req1_arready;

  assign hps_arvalid = (state_q == ST_ISSUE);
  assign hps_ar_hs   = hps_arvalid && hps_arready;
  assign hps_arid    = idx_to_id(idx_q);
  assign hps_araddr  = addr_q;
  assign hps_arlen   = len_q;
  assign hps_arsize  = size_q;
  assign hps_arburst = AXI_BURST_INCR;
  assign hps_arcache = AXI_CACHE_DEF;
  assign hps_arprot  = AXI_PROT_DEF;
  assign hps_arlock  = AXI_LOCK_NORMAL;

  // AR FSM: accept one requester in IDLE, hold the bridge request in ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (req_hs) begin
      state_q <= ST_ISSUE;
    end else if (hps_ar_hs) begin
      state_q <= ST_IDLE;
    end
  end

  // Capture the winner's address payload at the requester handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
      size_q <= '0;
    end else if (req_hs) begin
      idx_q  <= win;
      addr_q <= win ? req1_araddr : req0_araddr;
      len_q  <= win ? req1_arlen  : req0_arlen;
      size_q <= win ? req1_arsize : req0_arsize;
    end
  end

  assign r_done = hps_rvalid && hps_rready && hps_rlast;
  assign inc0   = hps_ar_hs && (idx_q == 1'b0);
  assign inc1   = hps_ar_hs && (idx_q == 1'b1);
  assign dec0   = r_done && (hps_rid[0] == 1'b0);
  assign dec1   = r_done && (hps_rid[0] == 1'b1);

  // Outstanding bursts per requester: bridge AR handshake in, last R beat out
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt_next(cnt0_q, inc0, dec0);
      cnt1_q <= cnt_next(cnt1_q, inc1, dec1);
    end
  end

  // R routing is purely combinational and keyed on rid[0]
  assign req0_rvalid = hps_rvalid && (hps_rid[0] == 1'b0);
  assign req1_rvalid = hps_rvalid && (hps_rid[0] == 1'b1);
  assign hps_rready  = hps_rid[0] ? req1_rready : req0_rready;
  assign req0_rdata  = hps_rdata;
  assign req1_rdata  = hps_rdata;
  assign req0_rresp  = hps_rresp;
  assign req1_rresp  = hps_rresp;
  assign req0_rlast  = hps_rlast;
  assign req1_rlast  = hps_rlast;

  logic unused_rid;
  assign unused_rid = ^hps_rid[AXI_ID_W-1:1];

endmodule

// File: tb/tb_fpga2hps_rd_arb.sv
// tb/tb_fpga2hps_rd_arb.sv - directed scoreboard bench for fpga2hps_rd_arb
module tb_fpga2hps_rd_arb;

  localparam int MAX_OUTST = 2;
`ifdef FPGA2HPS_ARB_VIDEO_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_arvalid, req0_arready, req1_arvalid, req1_arready;
  logic [31:0] req0_araddr, req1_araddr;
  logic [3:0]  req0_arlen, req1_arlen;
  logic [2:0]  req0_arsize, req1_arsize;
  logic        req0_rvalid, req0_rready, req0_rlast, req1_rvalid, req1_rready, req1_rlast;
  logic [31:0] req0_rdata, req1_rdata;
  logic [1:0]  req0_rresp, req1_rresp;
  logic        hps_arvalid, hps_arready;
  logic [7:0]  hps_arid;
  logic [31:0] hps_araddr;
  logic [3:0]  hps_arlen;
  logic [2:0]  hps_arsize;
  logic [1:0]  hps_arburst;
  logic [3:0]  hps_arcache;
  logic [2:0]  hps_arprot;
  logic [1:0]  hps_arlock;
  logic        hps_rvalid, hps_rready, hps_rlast;
  logic [7:0]  hps_rid;
  logic [31:0] hps_rdata;
  logic [1:0]  hps_rresp;

  fpga2hps_rd_arb #(.MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst),
    .req0_arvalid(req0_arvalid), .req0_arready(req0_arready), .req0_araddr(req0_araddr),
    .req0_arlen(req0_arlen), .req0_arsize(req0_arsize),
    .req0_rvalid(req0_rvalid), .req0_rready(req0_rready), .req0_rdata(req0_rdata),
    .req0_rresp(req0_rresp), .req0_rlast(req0_rlast),
    .req1_arvalid(req1_arvalid), .req1_arready(req1_arready), .req1_araddr(req1_araddr),
    .req1_arlen(req1_arlen), .req1_arsize(req1_arsize),
    .req1_rvalid(req1_rvalid), .req1_rready(req1_rready), .req1_rdata(req1_rdata),
    .req1_rresp(req1_rresp), .req1_rlast(req1_rlast),
    .hps_arvalid(hps_arvalid), .hps_arready(hps_arready), .hps_arid(hps_arid),
    .hps_araddr(hps_araddr), .hps_arlen(hps_arlen), .hps_arsize(hps_arsize),
    .hps_arburst(hps_arburst), .hps_arcache(hps_arcache), .hps_arprot(hps_arprot),
    .hps_arlock(hps_arlock),
    .hps_rvalid(hps_rvalid), .hps_rready(hps_rready), .hps_rid(hps_rid),
    .hps_rdata(hps_rdata), .hps_rresp(hps_rresp), .hps_rlast(hps_rlast)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
  } ar_exp_t;

  typedef struct packed {
    logic        idx;
    logic [31:0] data;
    logic        last;
  } r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  logic    obs_grants[$];

  int n_tests = 0;
  int n_fail  = 0;

  // bench reference state
  logic    m_issue = 1'b0;
  logic    m_last  = 1'b1;
  ar_exp_t m_ar    = '0;
  int      m_cnt[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bridge AR handshakes pop the expected-request scoreboard
  always @(negedge clk) begin
    if (hps_arvalid === 1'b1 && hps_arready === 1'b1) begin
      chk("ar_sb_nonempty", 32'(ar_q.size() != 0), 32'd1);
      if (ar_q.size() != 0) begin
        ar_exp_t e;
        e = ar_q.pop_front();
        chk("sb_arid",   32'(hps_arid),   32'(e.id));
        chk("sb_araddr", hps_araddr,      e.addr);
        chk("sb_arlen",  32'(hps_arlen),  32'(e.len));
        chk("sb_arsize", 32'(hps_arsize), 32'(e.size));
        chk("sb_fixed",  32'({hps_arburst, hps_arcache, hps_arprot, hps_arlock}),
            32'({2'b01, 4'b0011, 3'b000, 2'b00}));
      end
      obs_grants.push_back(hps_arid[0]);
    end
  end

  // Requester R handshakes pop the expected-beat scoreboard
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic v, rd, l;
      logic [31:0] d;
      v  = (i == 0) ? req0_rvalid : req1_rvalid;
      rd = (i == 0) ? req0_rready : req1_rready;
      d  = (i == 0) ? req0_rdata  : req1_rdata;
      l  = (i == 0) ? req0_rlast  : req1_rlast;
      if (v === 1'b1 && rd === 1'b1) begin
        chk("r_sb_nonempty", 32'(r_q.size() != 0), 32'd1);
        if (r_q.size() != 0) begin
          r_exp_t e;
          e = r_q.pop_front();
          chk("sb_r_idx",  i,     32'(e.idx));
          chk("sb_rdata",  d,     e.data);
          chk("sb_rlast",  32'(l), 32'(e.last));
        end
      end
    end
  end

  // One clock: check combinational outputs against the reference, push expectations, advance
  task automatic step();
    logic    rid0, exp_rrdy, r_hs, ar_hs, e0, e1, w, g0, g1, rlast_s;
    ar_exp_t nxt;
    #1;
    rid0     = hps_rid[0];
    exp_rrdy = rid0 ? req1_rready : req0_rready;
    chk("req0_rvalid", 32'(req0_rvalid), 32'(hps_rvalid && !rid0));
    chk("req1_rvalid", 32'(req1_rvalid), 32'(hps_rvalid && rid0));
    chk("hps_rready",  32'(hps_rready),  32'(exp_rrdy));
    chk("req0_rdata",  req0_rdata, hps_rdata);
    chk("req1_rdata",  req1_rdata, hps_rdata);
    chk("rresp_rlast", 32'({req0_rresp, req1_rresp, req0_rlast, req1_rlast}),
        32'({hps_rresp, hps_rresp, hps_rlast, hps_rlast}));
    chk("hps_arvalid", 32'(hps_arvalid), 32'(m_issue));
    if (m_issue) begin
      chk("hold_arid",   32'(hps_arid),   32'(m_ar.id));
      chk("hold_araddr", hps_araddr,      m_ar.addr);
      chk("hold_arlen",  32'(hps_arlen),  32'(m_ar.len));
      chk("hold_arsize", 32'(hps_arsize), 32'(m_ar.size));
    end
    if (rst) begin
      chk("rst_arready", 32'({req0_arready, req1_arready}), 32'd0);
      @(posedge clk); #1;
      m_issue = 1'b0; m_last = 1'b1; m_ar = '0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      ar_q.delete();
    end else begin
      e0 = req0_arvalid && (m_cnt[0] < MAX_OUTST);
      e1 = req1_arvalid && (m_cnt[1] < MAX_OUTST);
      if (e0 && e1) w = PRIO ? 1'b0 : !m_last;
      else          w = !e0;
      g0 = !m_issue && e0 && !w;
      g1 = !m_issue && e1 && w;
      chk("req0_arready", 32'(req0_arready), 32'(g0));
      chk("req1_arready", 32'(req1_arready), 32'(g1));
      r_hs    = hps_rvalid && exp_rrdy;
      rlast_s = hps_rlast;
      ar_hs   = m_issue && hps_arready;
      if (r_hs) r_q.push_back('{rid0, hps_rdata, hps_rlast});
      nxt = w ? '{8'h01, req1_araddr, req1_arlen, req1_arsize}
              : '{8'h00, req0_araddr, req0_arlen, req0_arsize};
      if (g0 || g1) ar_q.push_back(nxt);
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        logic inc, dec;
        inc = ar_hs && (m_ar.id[0] == i[0]);
        dec = r_hs && rlast_s && (rid0 == i[0]);
        if (inc && !dec) m_cnt[i]++;
        else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
      end
      if (g0 || g1) begin
        m_issue = 1'b1;
        m_ar    = nxt;
        if (!PRIO) m_last = w;
      end else if (ar_hs) begin
        m_issue = 1'b0;
      end
    end
  endtask

  task automatic r_beat(input logic [7:0] id, input logic [31:0] data, input logic last);
    hps_rvalid = 1'b1; hps_rid = id; hps_rdata = data; hps_rlast = last;
    hps_rresp  = data[1:0];
    step();
    hps_rvalid = 1'b0; hps_rlast = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0] id;
    logic       last;
    logic       r0rdy;
  } beat_t;

  beat_t beats[7];

  initial begin
    m_cnt[0] = 0; m_cnt[1] = 0;
    rst = 1'b1;
    req0_arvalid = 0; req0_araddr = '0; req0_arlen = '0; req0_arsize = '0; req0_rready = 0;
    req1_arvalid = 0; req1_araddr = '0; req1_arlen = '0; req1_arsize = '0; req1_rready = 0;
    hps_arready = 0; hps_rvalid = 0; hps_rid = '0; hps_rdata = '0; hps_rresp = '0; hps_rlast = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state: payload zero, arready suppressed even with a request pending
    req0_arvalid = 1'b1; req0_araddr = 32'hDEAD_0000;
    #1;
    chk("rst_araddr", hps_araddr, 32'd0);
    chk("rst_arid_len_size", 32'({hps_arid, hps_arlen, hps_arsize}), 32'd0);
    chk("rst_fixed", 32'({hps_arburst, hps_arcache, hps_arprot, hps_arlock}),
        32'({2'b01, 4'b0011, 3'b000, 2'b00}));
    step();
    req0_arvalid = 1'b0;
    rst = 1'b0;
    step();

    // single read from requester 1
    hps_arready = 1'b1;
    req1_arvalid = 1'b1; req1_araddr = 32'h2000_0040; req1_arlen = 4'd3; req1_arsize = 3'd2;
    step();
    req1_arvalid = 1'b0;
    #1;
    chk("single_arvalid", 32'(hps_arvalid), 32'd1);
    chk("single_arid",    32'(hps_arid),    32'h01);
    chk("single_arlen",   32'(hps_arlen),   32'd3);
    step();
    step();
    req1_rready = 1'b1;
    for (int b = 0; b < 4; b++) r_beat(8'h01, 32'hD000_0000 + b, b == 3);
    step();

    // tie: both requesting continuously
    obs_grants.delete();
    req0_arvalid = 1'b1; req0_araddr = 32'h1000_0100; req0_arlen = 4'd7; req0_arsize = 3'd2;
    req1_arvalid = 1'b1; req1_araddr = 32'h3000_0200; req1_arlen = 4'd1; req1_arsize = 3'd2;
    repeat (8) step();
    step();
    step();
    chk("tie_count", obs_grants.size(), 32'd4);
    if (obs_grants.size() == 4) begin
      chk("tie_order", 32'({obs_grants[0], obs_grants[1], obs_grants[2], obs_grants[3]}),
          PRIO ? 32'b0011 : 32'b0101);
    end
    req0_arvalid = 1'b0; req1_arvalid = 1'b0;

    // interleaved R drain, rid[7:1] ignored, one back-pressured beat, one surplus rlast
    req0_rready = 1'b1;
    beats[0] = '{8'h00, 1'b0, 1'b1};
    beats[1] = '{8'h03, 1'b1, 1'b1};
    beats[2] = '{8'hFE, 1'b0, 1'b0};
    beats[3] = '{8'hFE, 1'b1, 1'b1};
    beats[4] = '{8'h01, 1'b1, 1'b1};
    beats[5] = '{8'h80, 1'b1, 1'b1};
    beats[6] = '{8'h00, 1'b1, 1'b1};
    for (int k = 0; k < 7; k++) begin
      req0_rready = beats[k].r0rdy;
      r_beat(beats[k].id, 32'hA500_0000 + k, beats[k].last);
    end
    req0_rready = 1'b1;
    step();

    // backpressure: bridge stalls for 5 cycles in ISSUE
    hps_arready = 1'b0;
    req1_arvalid = 1'b1; req1_araddr = 32'h4000_0000; req1_arlen = 4'd15; req1_arsize = 3'd1;
    step();
    req1_arvalid = 1'b0;
    req0_arvalid = 1'b1; req0_araddr = 32'h1100_0000; req0_arlen = 4'd0; req0_arsize = 3'd2;
    repeat (5) step();
    hps_arready = 1'b1;
    step();
    step();
    req0_arvalid = 1'b0;
    step();

    // limit: requester 0 fills to MAX_OUTST, requester 1 still served
    req0_arvalid = 1'b1;
    step();
    step();
    req1_arvalid = 1'b1;
    #1;
    chk("limit_req0_blocked", 32'(req0_arready), 32'd0);
    chk("limit_req1_granted", 32'(req1_arready), 32'd1);
    step();
    req1_arvalid = 1'b0;
    step();
    hps_rvalid = 1'b1; hps_rid = 8'h00; hps_rlast = 1'b1; hps_rdata = 32'h0000_1234;
    #1;
    chk("limit_still_blocked", 32'(req0_arready), 32'd0);
    step();
    hps_rvalid = 1'b0; hps_rlast = 1'b0;
    #1;
    chk("limit_reenabled", 32'(req0_arready), 32'd1);
    hps_arready = 1'b0;
    step();

    // simultaneous bridge AR handshake and rlast for requester 0
    hps_arready = 1'b1;
    hps_rvalid = 1'b1; hps_rid = 8'h00; hps_rlast = 1'b1; hps_rdata = 32'h0000_5678;
    step();
    hps_rvalid = 1'b0; hps_rlast = 1'b0;
    #1;
    chk("simul_one_slot_left", 32'(req0_arready), 32'd1);
    step();
    step();
    #1;
    chk("simul_full_again", 32'(req0_arready), 32'd0);
    req0_arvalid = 1'b0;

    // reset while ISSUE is holding a request
    r_beat(8'h00, 32'h0000_9ABC, 1'b1);
    req0_arvalid = 1'b1; req0_araddr = 32'h1200_0000;
    hps_arready = 1'b0;
    step();
    step();
    rst = 1'b1;
    req1_arvalid = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_issue_arvalid", 32'(hps_arvalid), 32'd0);
    chk("post_rst_tie_r0",   32'(req0_arready), 32'd1);
    chk("post_rst_tie_r1",   32'(req1_arready), 32'd0);
    obs_grants.delete();
    hps_arready = 1'b1;
    repeat (4) step();
    req0_arvalid = 1'b0; req1_arvalid = 1'b0;
    step();
    chk("post_rst_count", obs_grants.size(), 32'd2);
    if (obs_grants.size() == 2) begin
      chk("post_rst_order", 32'({obs_grants[0], obs_grants[1]}), PRIO ? 32'b00 : 32'b01);
    end

    // R beats after reset still routed by rid[0]
    r_beat(8'h01, 32'h0000_0011, 1'b1);
    r_beat(8'h00, 32'h0000_0022, 1'b1);
    r_beat(8'h00, 32'h0000_0033, 1'b1);
    step();

    chk("ar_sb_drained", ar_q.size(), 32'd0);
    chk("r_sb_drained",  r_q.size(),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
